// File: rtl/matriz_frame_scheduler.sv
// matriz_frame_scheduler
//   Plays a range of frames from a 16 x 32-bit on-chip buffer into the 4x8 LED
//   matrix controller. Each frame is held for a programmable number of ticks
//   (TICK_DIV clocks each). Playback is one-shot or looping.
//
// Ports
//   clk12Mhz            system clock
//   rst                 asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_ready
//                       frame write port; a write happens when wr_en & wr_ready
//                       are both high at a clock edge
//   start/stop          single-cycle control pulses (stop has priority)
//   loop/first/last/hold_ms
//                       playback settings, sampled on a start accepted in IDLE
//   busy                high while a frame is being loaded or shown
//   cur_frame           index of the frame currently on the LEDs
//   done                one-cycle pulse when one-shot playback completes
//   leds1..leds4        row data, frame bits [7:0],[15:8],[23:16],[31:24]
module matriz_frame_scheduler #(
  parameter int TICK_DIV = 12000,
  parameter int DEPTH    = 16
) (
  input  logic        clk12Mhz,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [3:0]  first,
  input  logic [3:0]  last,
  input  logic [11:0] hold_ms,
  output logic        busy,
  output logic [3:0]  cur_frame,
  output logic        done,
  output logic [7:0]  leds1,
  output logic [7:0]  leds2,
  output logic [7:0]  leds3,
  output logic [7:0]  leds4
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [3:0]    ptr;
  logic [3:0]    first_lat;
  logic [3:0]    last_lat;
  logic          loop_lat;
  logic [11:0]   hold_lat;
  logic [11:0]   hold_cnt;
  logic [PW-1:0] presc;
  logic          tick_end;
  logic          frame_end;
  logic          range_end;

  assign wr_ready = (state != LOAD);
  assign busy     = (state != IDLE);

  // Memory has no reset; it is only ever read in LOAD, never on the write port.
  always_ff @(posedge clk12Mhz) begin
    if (wr_en && wr_ready) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_next = state;
    tick_end   = (state == SHOW) && (presc == PW'(TICK_DIV - 1));
    frame_end  = tick_end && (hold_cnt == 12'd1);
    range_end  = (ptr == last_lat);
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SHOW;
      SHOW:    if (frame_end) state_next = (range_end && !loop_lat) ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
    if (stop) state_next = IDLE;
  end

  always_ff @(posedge clk12Mhz or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      first_lat <= '0;
      last_lat  <= '0;
      loop_lat  <= 1'b0;
      hold_lat  <= 12'd1;
      hold_cnt  <= '0;
      presc     <= '0;
      cur_frame <= '0;
      done      <= 1'b0;
      leds1     <= '0;
      leds2     <= '0;
      leds3     <= '0;
      leds4     <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            first_lat <= first;
            last_lat  <= last;
            loop_lat  <= loop;
            hold_lat  <= (hold_ms == '0) ? 12'd1 : hold_ms;
            ptr       <= first;
          end
        end
        LOAD: begin
          {leds4, leds3, leds2, leds1} <= mem[ptr];
          cur_frame <= ptr;
          presc     <= '0;
          hold_cnt  <= hold_lat;
        end
        SHOW: begin
          if (tick_end) begin
            presc    <= '0;
            hold_cnt <= hold_cnt - 12'd1;
          end else begin
            presc <= presc + 1'b1;
          end
          if (frame_end) begin
            if (!range_end)    ptr  <= ptr + 4'd1;
            else if (loop_lat) ptr  <= first_lat;
            else               done <= !stop;
          end
        end
        default: ;
      endcase
      // Stop blanks the display even when it lands on a LOAD cycle.
      if (stop) begin
        leds1 <= '0;
        leds2 <= '0;
        leds3 <= '0;
        leds4 <= '0;
      end
    end
  end

endmodule

// File: doc/matriz_frame_scheduler.md
Name: matriz_frame_scheduler

Overview:
- Frame sequencer that drives the 4x8 LED matrix controller's leds1..leds4 inputs from a 16-frame on-chip buffer.
- Plays a programmable range of frames, each held for a programmable number of milliseconds, in one-shot or loop mode.
- Host logic (VGA pattern/debug logic) loads frames through a ready/enable write port and starts or stops playback with pulses.

Parameters:
TICK_DIV, 12000, clk12Mhz cycles per hold tick (1 ms at 12 MHz); must be >=2; set to 4 in simulation.
DEPTH, 16, number of 32-bit frames; fixed at 16 (4-bit addresses).

Ports:
clk12Mhz  in  1  system clock, 12 MHz
rst  in  1  asynchronous active-low reset
wr_en  in  1  frame write request
wr_addr  in  4  frame index to write
wr_data  in  32  frame: [7:0]=row1, [15:8]=row2, [23:16]=row3, [31:24]=row4
wr_ready  out  1  write accepted when wr_en&wr_ready at clock edge
start  in  1  single-cycle start pulse
stop  in  1  single-cycle stop pulse
loop  in  1  1 = repeat range, 0 = one-shot; sampled at start
first  in  4  first frame of range; sampled at start
last  in  4  last frame of range; sampled at start
hold_ms  in  12  ticks per frame; sampled at start; 0 treated as 1
busy  out  1  high in LOAD/SHOW
cur_frame  out  4  index of frame on display
done  out  1  one-cycle pulse at end of one-shot playback
leds1..leds4  out  8 each  row data to the matrix controller (1 = LED on)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; leds1..4=0; cur_frame=0; busy=0; done=0; wr_ready=1; prescaler and hold counter=0. Frame memory is not reset; contents are undefined until written.
- Memory: single-port 16x32 array.
  - Write occurs on a clock edge with wr_en=1 and wr_ready=1.
  - wr_ready=0 only in LOAD; a wr_en asserted then is ignored, and the requester holds it.
- State IDLE:
  - On start=1 and stop=0: latch first, last, loop and max(hold_ms,1); ptr=first; go to LOAD.
  - Outputs keep their last values.
- State LOAD (exactly 1 cycle):
  - Read mem[ptr] into leds1..4; cur_frame=ptr.
  - Clear the prescaler; load the hold counter with the latched hold value.
  - Go to SHOW.
- State SHOW:
  - The prescaler counts 0..TICK_DIV-1. On the wrap, the hold counter decrements.
  - When the hold counter reaches 0:
    - If ptr==last and loop=1: ptr=first; go to LOAD.
    - If ptr==last and loop=0: pulse done for 1 cycle; go to IDLE; frame stays displayed.
    - Otherwise: ptr=ptr+1 modulo 16; go to LOAD.
- Timing:
  - New frame data appears on leds one cycle after LOAD is entered.
  - Each frame occupies hold*TICK_DIV+1 cycles (LOAD + SHOW).
  - Frame period is exact and independent of writes.
- Range wrap: if first>last, playback wraps 15->0 (e.g. 14,15,0,1). If first==last, one frame is shown; with loop=1 it is reloaded each period, so rewrites become visible.
- stop=1 in any state:
  - Next state IDLE; leds1..4=0; busy=0; no done pulse.
  - stop wins over a simultaneous start and over a simultaneous end-of-range.
- start while busy is ignored; range, loop and hold are unchanged until the next start from IDLE.
- Writes during SHOW, including to the displayed or next frame, are accepted. The new value appears at that frame's next LOAD.
- Reset mid-playback aborts immediately to the reset state.

Test Plan:
1. Reset then idle (TICK_DIV=4) -> all outputs 0, wr_ready=1, busy=0.
2. Write frames 0..3 = 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000; start first=0 last=3 hold_ms=2 loop=0 -> frames advance every 9 cycles; leds1=0xFF, then leds2=0xFF, and so on. Single done pulse after frame 3; busy falls; leds4=0xFF retained.
3. loop=1, first=14, last=1 -> cur_frame sequence 14,15,0,1,14,... Assert stop mid-frame -> next cycle leds=0, busy=0, done never pulses.
4. hold_ms=0, single frame, one-shot -> frame lasts TICK_DIV+1 cycles (treated as 1).
5. Hold wr_en during LOAD -> wr_ready=0 that cycle and no write. Write accepted the following cycle. Rewrite the displayed frame 5 to 0xA5A5A5A5 with loop first=last=5 -> shown at next reload.
6. Pulse start and stop in the same cycle from IDLE -> stays IDLE. Assert rst low mid-SHOW -> outputs 0 asynchronously, before the next clock edge.
